// File: rtl/fft_demux_1x2048_if.sv
// Serial sample stream feeding the 1:2048 scatter bank.
interface fft_demux_1x2048_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fft_demux_1x2048.sv
// 1:2048 scatter of a serial sample stream into a parallel FFT input bank.
// Write decode runs over three registered stages (1:8 group, then 1:16 x 1:16).
module fft_demux_1x2048 #(
    parameter int DATA_WIDTH  = 8,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_demux_1x2048_if.slave     s,
    output logic [DATA_WIDTH-1:0] data_o [2048],
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic [11:0]           wr_count,
    output logic                  err_last
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  drain_q, drain_d;
    logic [11:0]           wr_count_q, wr_count_d;
    logic                  err_last_q, err_last_d;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [10:0]           s1_addr_q, s1_addr_d;
    logic                  s1_err_q, s1_err_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [7:0]            s2_grp_q, s2_grp_d;
    logic [7:0]            s2_low_q, s2_low_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [DATA_WIDTH-1:0] data_q [2048];
    logic [DATA_WIDTH-1:0] data_d [2048];

    logic        accept;
    logic [10:0] cnt, cnt_rev, addr;
    logic [7:0]  grp_dec;
    logic [15:0] hi_dec, lo_dec;
    logic [2047:0] we;

    assign accept = s.s_valid && s_ready_q;
    // In FILL the count never exceeds 2047, so its low 11 bits are the sample index.
    assign cnt  = wr_count_q[10:0];
    assign addr = BIT_REVERSE ? cnt_rev : cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_rev
            assign cnt_rev[gi] = cnt[10-gi];
        end
        for (gi = 0; gi < 8; gi++) begin : g_grp
            assign grp_dec[gi] = (s1_addr_q[10:8] == 3'(gi));
        end
        for (gi = 0; gi < 16; gi++) begin : g_hl
            assign hi_dec[gi] = (s2_low_q[7:4] == 4'(gi));
            assign lo_dec[gi] = (s2_low_q[3:0] == 4'(gi));
        end
        for (gi = 0; gi < 2048; gi++) begin : g_bank
            assign we[gi]     = s2_valid_q && s2_grp_q[gi/256] && hi_dec[(gi/16)%16] && lo_dec[gi%16];
            assign data_d[gi] = we[gi] ? s2_data_q : data_q[gi];
            assign data_o[gi] = data_q[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FILL;
            FILL:    if (accept && cnt == 11'd2047) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = HOLD;
            HOLD:    if (frame_ack) state_d = FILL;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; handshake outputs are registered from the next state.
    always_comb begin
        s_ready_d     = (state_d == FILL);
        frame_valid_d = (state_d == HOLD);
        drain_d       = (state_q == DRAIN) ? ~drain_q : 1'b0;
        wr_count_d    = wr_count_q;
        if (accept) begin
            wr_count_d = wr_count_q + 12'd1;
        end
        if (state_q == HOLD && frame_ack) begin
            wr_count_d = 12'd0;
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = accept ? s.s_data : s1_data_q;
        s1_addr_d  = accept ? addr : s1_addr_q;
        s1_err_d   = accept && (s.s_last != (cnt == 11'd2047));
        err_last_d = s1_err_q;
        s2_valid_d = s1_valid_q;
        s2_grp_d   = grp_dec;
        s2_low_d   = s1_addr_q[7:0];
        s2_data_d  = s1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            drain_q       <= 1'b0;
            wr_count_q    <= 12'd0;
            err_last_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_addr_q     <= 11'd0;
            s1_err_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_grp_q      <= 8'd0;
            s2_low_q      <= 8'd0;
            s2_data_q     <= '0;
            for (int i = 0; i < 2048; i++) data_q[i] <= '0;
        end else begin
            s_ready_q     <= s_ready_d;
            frame_valid_q <= frame_valid_d;
            drain_q       <= drain_d;
            wr_count_q    <= wr_count_d;
            err_last_q    <= err_last_d;
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_addr_q     <= s1_addr_d;
            s1_err_q      <= s1_err_d;
            s2_valid_q    <= s2_valid_d;
            s2_grp_q      <= s2_grp_d;
            s2_low_q      <= s2_low_d;
            s2_data_q     <= s2_data_d;
            data_q        <= data_d;
        end
    end

    assign s.s_ready   = s_ready_q;
    assign frame_valid = frame_valid_q;
    assign wr_count    = wr_count_q;
    assign err_last    = err_last_q;
endmodule

// File: tb/tb_fft_demux_1x2048.sv
// Drives a natural-order and a bit-reversed instance with identical stimulus and
// compares both against a frame-level reference model.
module tb_fft_demux_1x2048;
    localparam int N = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_valid = 1'b0, s_last = 1'b0, frame_ack = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       rdy0, rdy1, fv0, fv1, err0, err1;
    logic [11:0] cnt0, cnt1;
    logic [7:0] bank0 [N];
    logic [7:0] bank1 [N];

    fft_demux_1x2048_if #(.DATA_WIDTH(8)) sif0 ();
    fft_demux_1x2048_if #(.DATA_WIDTH(8)) sif1 ();
    assign sif0.s_valid = s_valid;
    assign sif0.s_data  = s_data;
    assign sif0.s_last  = s_last;
    assign sif1.s_valid = s_valid;
    assign sif1.s_data  = s_data;
    assign sif1.s_last  = s_last;
    assign rdy0 = sif0.s_ready;
    assign rdy1 = sif1.s_ready;

    fft_demux_1x2048 #(.DATA_WIDTH(8), .BIT_REVERSE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(sif0), .data_o(bank0), .frame_valid(fv0),
        .frame_ack(frame_ack), .wr_count(cnt0), .err_last(err0));
    fft_demux_1x2048 #(.DATA_WIDTH(8), .BIT_REVERSE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(sif1), .data_o(bank1), .frame_valid(fv1),
        .frame_ack(frame_ack), .wr_count(cnt1), .err_last(err1));

    // Reference model: frame contents plus a list of writes with their due cycle.
    typedef struct { int i0; int i1; logic [7:0] d; int due; } wr_t;
    wr_t        pend[$];
    logic [7:0] exp0 [N];
    logic [7:0] exp1 [N];
    bit  exp_ready, exp_fv, exp_err, err_pend, fresh;
    int  exp_count, drain, cyc;
    int  checks = 0, failures = 0;

    function automatic int bitrev11(input int n);
        int r = 0;
        for (int b = 0; b < 11; b++) if (n[b]) r = r | (1 << (10 - b));
        return r;
    endfunction

    function automatic int bank_diff();
        for (int k = 0; k < N; k++)
            if (bank0[k] !== exp0[k] || bank1[k] !== exp1[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int k = 0; k < N; k++) begin exp0[k] = 8'd0; exp1[k] = 8'd0; end
        exp_ready = 0; exp_fv = 0; exp_err = 0; err_pend = 0;
        exp_count = 0; drain = 0; fresh = 1;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ack);
        bit acc, mism, hold_ack;
        s_valid = v; s_data = d; s_last = l; frame_ack = ack;
        acc      = v && exp_ready;
        mism     = acc && (l != (exp_count == N - 1));
        hold_ack = exp_fv && ack;
        @(posedge clk);
        cyc++;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            exp0[pend[0].i0] = pend[0].d;
            exp1[pend[0].i1] = pend[0].d;
            void'(pend.pop_front());
        end
        exp_err  = err_pend;
        err_pend = mism;
        if (drain > 0) begin
            drain--;
            if (drain == 0) exp_fv = 1;
        end
        if (acc) begin
            pend.push_back('{i0: exp_count, i1: bitrev11(exp_count), d: d, due: cyc + 2});
            exp_count++;
            if (exp_count == N) begin exp_ready = 0; drain = 2; end
        end
        if (hold_ack) begin exp_fv = 0; exp_ready = 1; exp_count = 0; end
        if (fresh) begin exp_ready = 1; fresh = 0; end
        #1;
    endtask

    task automatic test_reset();
        int d;
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({rdy0, rdy1, fv0, fv1, err0, err1} !== 6'b0 || cnt0 !== 12'd0 || cnt1 !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b%b fv=%b%b err=%b%b cnt=%0d/%0d want all 0",
                     rdy0, rdy1, fv0, fv1, err0, err1, cnt0, cnt1);
        end
        d = bank_diff();
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL reset_bank idx=%0d got %h/%h want 00/00", d, bank0[d], bank1[d]);
        end
        #10 rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b%b want 1", rdy0, rdy1);
        end
    endtask

    task automatic test_full_rate();
        int errs = 0, d;
        for (int n = 0; n < N; n++) begin
            step(1'b1, 8'(n), n == N - 1, 1'b0);
            errs += int'(err0) + int'(err1);
            checks++;
            if (rdy0 !== exp_ready || rdy1 !== exp_ready || cnt0 !== 12'(exp_count) || cnt1 !== 12'(exp_count)
                || fv0 !== exp_fv || fv1 !== exp_fv || err0 !== exp_err || err1 !== exp_err) begin
                failures++;
                $display("FAIL full_status n=%0d got rdy=%b%b cnt=%0d/%0d fv=%b%b err=%b%b want rdy=%b cnt=%0d fv=%b err=%b",
                         n, rdy0, rdy1, cnt0, cnt1, fv0, fv1, err0, err1, exp_ready, exp_count, exp_fv, exp_err);
            end
        end
        step(1'b0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (fv0 !== 1'b0 || fv1 !== 1'b0) begin
            failures++;
            $display("FAIL full_fv_early got %b%b want 0", fv0, fv1);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (fv0 !== 1'b1 || fv1 !== 1'b1 || cnt0 !== 12'd2048 || cnt1 !== 12'd2048) begin
            failures++;
            $display("FAIL full_fv_rise got fv=%b%b cnt=%0d/%0d want fv=1 cnt=2048", fv0, fv1, cnt0, cnt1);
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL full_err_last got %0d pulses want 0", errs);
        end
        d = bank_diff();
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL full_bank idx=%0d got %h/%h want %h/%h", d, bank0[d], bank1[d], exp0[d], exp1[d]);
        end
        checks++;
        if (bank1[1024] !== 8'h01 || bank1[1536] !== 8'h03 || bank1[1] !== 8'h00 || bank1[2047] !== 8'hFF) begin
            failures++;
            $display("FAIL bitrev_spots got %h %h %h %h want 01 03 00 ff",
                     bank1[1024], bank1[1536], bank1[1], bank1[2047]);
        end
        checks++;
        if (bank0[1024] !== 8'h00 || bank0[3] !== 8'h03 || bank0[2047] !== 8'hFF) begin
            failures++;
            $display("FAIL natural_spots got %h %h %h want 00 03 ff", bank0[1024], bank0[3], bank0[2047]);
        end
    endtask

    task automatic test_hold_handoff();
        int d;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0);
            checks++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || cnt0 !== 12'd2048 || cnt1 !== 12'd2048 || fv0 !== 1'b1 || fv1 !== 1'b1) begin
                failures++;
                $display("FAIL hold_status c=%0d got rdy=%b%b cnt=%0d/%0d fv=%b%b want rdy=0 cnt=2048 fv=1",
                         c, rdy0, rdy1, cnt0, cnt1, fv0, fv1);
            end
        end
        d = bank_diff();
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL hold_bank idx=%0d got %h/%h want %h/%h", d, bank0[d], bank1[d], exp0[d], exp1[d]);
        end
        step(1'b0, 8'd0, 1'b0, 1'b1);
        checks++;
        if (fv0 !== 1'b0 || fv1 !== 1'b0 || rdy0 !== 1'b1 || rdy1 !== 1'b1 || cnt0 !== 12'd0 || cnt1 !== 12'd0) begin
            failures++;
            $display("FAIL handoff got fv=%b%b rdy=%b%b cnt=%0d/%0d want fv=0 rdy=1 cnt=0",
                     fv0, fv1, rdy0, rdy1, cnt0, cnt1);
        end
        frame_ack = 1'b0;
    endtask

    // Random gaps; the whole bank is compared every cycle so each write must land exactly on time.
    task automatic test_gapped();
        int d;
        for (int c = 0; c < 8000 && !exp_fv; c++) begin
            step(1'($urandom % 2), 8'(~exp_count), exp_count == N - 1, 1'b0);
            checks++;
            if (rdy0 !== exp_ready || rdy1 !== exp_ready || cnt0 !== 12'(exp_count) || cnt1 !== 12'(exp_count)
                || fv0 !== exp_fv || fv1 !== exp_fv || err0 !== exp_err || err1 !== exp_err) begin
                failures++;
                $display("FAIL gapped_status c=%0d got rdy=%b%b cnt=%0d/%0d fv=%b%b err=%b%b want rdy=%b cnt=%0d fv=%b err=%b",
                         c, rdy0, rdy1, cnt0, cnt1, fv0, fv1, err0, err1, exp_ready, exp_count, exp_fv, exp_err);
            end
            d = bank_diff();
            checks++;
            if (d !== -1) begin
                failures++;
                $display("FAIL gapped_bank c=%0d idx=%0d got %h/%h want %h/%h", c, d, bank0[d], bank1[d], exp0[d], exp1[d]);
            end
        end
        checks++;
        if (fv0 !== 1'b1 || fv1 !== 1'b1) begin
            failures++;
            $display("FAIL gapped_timeout got fv=%b%b want 1", fv0, fv1);
        end
        step(1'b0, 8'd0, 1'b0, 1'b1);
        frame_ack = 1'b0;
    endtask

    task automatic test_last_mismatch();
        int errs = 0, d;
        for (int c = 0; c < 8000 && !exp_fv; c++) begin
            step(($urandom % 4) != 0, 8'($urandom), exp_count == 100, 1'b0);
            errs += int'(err0);
            checks++;
            if (rdy0 !== exp_ready || rdy1 !== exp_ready || cnt0 !== 12'(exp_count) || cnt1 !== 12'(exp_count)
                || fv0 !== exp_fv || fv1 !== exp_fv || err0 !== exp_err || err1 !== exp_err) begin
                failures++;
                $display("FAIL last_status c=%0d got rdy=%b%b cnt=%0d/%0d fv=%b%b err=%b%b want rdy=%b cnt=%0d fv=%b err=%b",
                         c, rdy0, rdy1, cnt0, cnt1, fv0, fv1, err0, err1, exp_ready, exp_count, exp_fv, exp_err);
            end
        end
        checks++;
        if (errs != 2) begin
            failures++;
            $display("FAIL last_pulse_count got %0d want 2", errs);
        end
        d = bank_diff();
        checks++;
        if (d !== -1 || fv0 !== 1'b1) begin
            failures++;
            $display("FAIL last_frame idx=%0d fv=%b want idx=-1 fv=1", d, fv0);
        end
        step(1'b0, 8'd0, 1'b0, 1'b1);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int d;
        for (int c = 0; c < 4000 && exp_count < 500; c++)
            step(1'($urandom % 2), 8'($urandom), 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        d = bank_diff();
        checks++;
        if (d !== -1 || {rdy0, rdy1, fv0, fv1} !== 4'b0 || cnt0 !== 12'd0 || cnt1 !== 12'd0) begin
            failures++;
            $display("FAIL midreset_async idx=%0d rdy=%b%b fv=%b%b cnt=%0d/%0d want idx=-1 all 0",
                     d, rdy0, rdy1, fv0, fv1, cnt0, cnt1);
        end
        #2 rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        d = bank_diff();
        checks++;
        if (d !== -1 || rdy0 !== 1'b1 || rdy1 !== 1'b1 || cnt0 !== 12'd0) begin
            failures++;
            $display("FAIL midreset_release idx=%0d rdy=%b%b cnt=%0d want idx=-1 rdy=1 cnt=0", d, rdy0, rdy1, cnt0);
        end
        for (int c = 0; c < 8000 && !exp_fv; c++) begin
            step(($urandom % 3) != 0, 8'($urandom), exp_count == N - 1, 1'b0);
            checks++;
            if (rdy0 !== exp_ready || rdy1 !== exp_ready || cnt0 !== 12'(exp_count) || cnt1 !== 12'(exp_count)
                || fv0 !== exp_fv || fv1 !== exp_fv || err0 !== exp_err || err1 !== exp_err) begin
                failures++;
                $display("FAIL refill_status c=%0d got rdy=%b%b cnt=%0d/%0d fv=%b%b err=%b%b want rdy=%b cnt=%0d fv=%b err=%b",
                         c, rdy0, rdy1, cnt0, cnt1, fv0, fv1, err0, err1, exp_ready, exp_count, exp_fv, exp_err);
            end
        end
        d = bank_diff();
        checks++;
        if (d !== -1 || fv0 !== 1'b1 || fv1 !== 1'b1) begin
            failures++;
            $display("FAIL refill_frame idx=%0d fv=%b%b want idx=-1 fv=1", d, fv0, fv1);
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_full_rate();
        test_hold_handoff();
        test_gapped();
        test_last_mismatch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
